// File: rtl/adpcm_xor_if.sv
// Signal bundle between the inverse quantizer / delay line and the XOR block:
// current and delayed quantized differences in, sign-correlation term out.
interface adpcm_xor_if;
    logic [15:0] DQ;
    logic [10:0] DQn;
    logic        Un;

    modport master (output DQ, output DQn, input Un);
    modport slave  (input DQ, input DQn, output Un);
endinterface

// File: rtl/adpcm_xor.sv
// G.726 ADPCM XOR block: Un = sign(DQ) ^ sign(DQn) for the zero-predictor update.
// Combinational by default; REGISTERED=1 adds one flop with async active-low clear.
module adpcm_xor #(
    parameter bit REGISTERED = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scan_in0,
    input  logic        scan_in1,
    input  logic        scan_in2,
    input  logic        scan_in3,
    input  logic        scan_in4,
    input  logic        scan_enable,
    input  logic        test_mode,
    adpcm_xor_if.slave  bus,
    output logic        scan_out0,
    output logic        scan_out1,
    output logic        scan_out2,
    output logic        scan_out3,
    output logic        scan_out4
);

    logic un_d;
    // Magnitude/exponent/mantissa bits and DFT hooks are deliberately unused.
    logic unused_bits;

    assign un_d = bus.DQ[15] ^ bus.DQn[10];

    assign unused_bits = &{1'b0, bus.DQ[14:0], bus.DQn[9:0], clk, reset,
                           scan_in0, scan_in1, scan_in2, scan_in3, scan_in4,
                           scan_enable, test_mode};

    assign scan_out0 = 1'b0;
    assign scan_out1 = 1'b0;
    assign scan_out2 = 1'b0;
    assign scan_out3 = 1'b0;
    assign scan_out4 = 1'b0;

    generate
        if (REGISTERED) begin : g_reg
            logic un_q;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) un_q <= 1'b0;
                else        un_q <= un_d;
            end

            assign bus.Un = un_q;
        end else begin : g_comb
            assign bus.Un = un_d;
        end
    endgenerate

endmodule

// File: tb/tb_adpcm_xor.sv
// Self-checking bench for adpcm_xor: combinational and registered instances
// driven in parallel, vector table plus random sweep and reset corner cases.
module tb_adpcm_xor;

    logic       clk;
    logic       reset;
    logic [4:0] si;
    logic       scan_enable;
    logic       test_mode;
    wire  [4:0] so_c;
    wire  [4:0] so_r;

    adpcm_xor_if bus_c ();
    adpcm_xor_if bus_r ();

    adpcm_xor #(.REGISTERED(1'b0)) u_comb (
        .clk(clk), .reset(reset),
        .scan_in0(si[0]), .scan_in1(si[1]), .scan_in2(si[2]),
        .scan_in3(si[3]), .scan_in4(si[4]),
        .scan_enable(scan_enable), .test_mode(test_mode),
        .bus(bus_c),
        .scan_out0(so_c[0]), .scan_out1(so_c[1]), .scan_out2(so_c[2]),
        .scan_out3(so_c[3]), .scan_out4(so_c[4])
    );

    adpcm_xor #(.REGISTERED(1'b1)) u_reg (
        .clk(clk), .reset(reset),
        .scan_in0(si[0]), .scan_in1(si[1]), .scan_in2(si[2]),
        .scan_in3(si[3]), .scan_in4(si[4]),
        .scan_enable(scan_enable), .test_mode(test_mode),
        .bus(bus_r),
        .scan_out0(so_r[0]), .scan_out1(so_r[1]), .scan_out2(so_r[2]),
        .scan_out3(so_r[3]), .scan_out4(so_r[4])
    );

    typedef struct {
        string       name;
        logic [15:0] dq;
        logic [10:0] dqn;
        logic        un;
    } vec_t;

    vec_t vecs[6];
    logic exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check_scan(input string name);
        check({name, "_scan"}, |{so_c, so_r}, 1'b0);
    endtask

    task automatic drive(input logic [15:0] dq, input logic [10:0] dqn);
        bus_c.DQ    = dq;
        bus_c.DQn   = dqn;
        bus_r.DQ    = dq;
        bus_r.DQn   = dqn;
        si          = 5'($urandom);
        scan_enable = 1'($urandom);
        test_mode   = 1'($urandom);
    endtask

    // One full clock period: drive with clk low, check comb path, then the
    // registered path one edge later from the scoreboard queue.
    task automatic cycle(input string name, input logic [15:0] dq,
                         input logic [10:0] dqn, input logic exp);
        logic e;
        drive(dq, dqn);
        exp_q.push_back(exp);
        #1;
        check({name, "_comb"}, bus_c.Un, exp);
        #4 clk = 1'b1;
        #1;
        if (exp_q.size() == 0) begin
            check({name, "_sb_empty"}, 1'b1, 1'b0);
        end else begin
            e = exp_q.pop_front();
            check({name, "_reg"}, bus_r.Un, e);
        end
        check_scan(name);
        #4 clk = 1'b0;
    endtask

    initial begin
        logic        s1, s2;
        logic [15:0] dq;
        logic [10:0] dqn;

        vecs[0] = '{"both_pos",  16'h0005, 11'h045, 1'b0};
        vecs[1] = '{"dq_neg",    16'h8005, 11'h045, 1'b1};
        vecs[2] = '{"dqn_neg",   16'h0005, 11'h445, 1'b1};
        vecs[3] = '{"both_neg",  16'hFFFF, 11'h7FF, 1'b0};
        vecs[4] = '{"neg_zero",  16'h8000, 11'h000, 1'b1};
        vecs[5] = '{"pos_zero",  16'h0000, 11'h000, 1'b0};

        clk   = 1'b0;
        reset = 1'b1;
        drive(16'h0000, 11'h000);
        #10;

        for (int unsigned i = 0; i < 6; i++)
            cycle(vecs[i].name, vecs[i].dq, vecs[i].dqn, vecs[i].un);

        for (int unsigned i = 0; i < 1000; i++) begin
            s1  = 1'($urandom);
            s2  = 1'($urandom);
            dq  = {s1, 15'($urandom)};
            dqn = {s2, 10'($urandom)};
            cycle("rand", dq, dqn, s1 ^ s2);
        end

        // Preload the flop with 1, then reset with clk held low.
        drive(16'h8000, 11'h000);
        #1 clk = 1'b1;
        #1 check("preload_reg", bus_r.Un, 1'b1);
        #4 clk = 1'b0;
        #4 reset = 1'b0;
        #1;
        check("async_reset_reg", bus_r.Un, 1'b0);
        check("comb_ignores_reset", bus_c.Un, 1'b1);
        #4 clk = 1'b1;
        #1 check("reset_holds_reg", bus_r.Un, 1'b0);
        check_scan("in_reset");
        #4 clk = 1'b0;
        #4 reset = 1'b1;
        #1 check("release_no_edge_reg", bus_r.Un, 1'b0);
        #4 clk = 1'b1;
        #1 check("first_edge_reg", bus_r.Un, 1'b1);
        #4 clk = 1'b0;

        cycle("post_rel_a", 16'h0005, 11'h445, 1'b1);
        cycle("post_rel_b", 16'h8005, 11'h445, 1'b0);
        cycle("pre_mid",    16'h8123, 11'h000, 1'b1);

        // Mid-stream reset while the flop holds 1 and clk is high.
        #4 clk = 1'b1;
        #1 check("pre_mid_hold_reg", bus_r.Un, 1'b1);
        reset = 1'b0;
        #1 check("midstream_reset_reg", bus_r.Un, 1'b0);
        check("midstream_comb", bus_c.Un, 1'b1);
        #3 clk = 1'b0;
        #4 reset = 1'b1;
        #1;
        exp_q.delete();

        cycle("resume_a", 16'h7FFF, 11'h400, 1'b1);
        cycle("resume_b", 16'h7FFF, 11'h3FF, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
